id_ex_stage_reg: RTL and testbench

Parametrised ID/EX pipeline register for the MIPS datapath, sitting between the decode stage and the execute stage. It registers control fields (WB, M, EX), PC, instruction, operands, immediate and register specifiers, and adds what the previous generation lacked:

- synchronous reset;
- a valid bit;
- stall (hold) and flush (bubble insertion) for the hazard unit;
- the `rs` specifier for forwarding;
- two saturating event counters for pipeline statistics.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 20 ++
 rtl/id_ex_stage_reg.sv | 117 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline registers: default field widths,
// the ID/EX control bundle and the all-zero bubble control word.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int PC_W    = 8;
    localparam int WB_W    = 2;
    localparam int M_W     = 3;
    localparam int EX_W    = 4;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;

    // Control bundle carried from decode to execute, most significant field first.
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } idex_ctrl_t;

    // A bubble never asserts any write or memory control downstream.
    localparam idex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc unless already at the top value; rst clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, hazard-unit stall/flush and
// saturating stall/bubble statistics counters.
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W          = pipe_pkg::DATA_W,
    parameter int PC_W            = pipe_pkg::PC_W,
    parameter int WB_W            = pipe_pkg::WB_W,
    parameter int M_W             = pipe_pkg::M_W,
    parameter int EX_W            = pipe_pkg::EX_W,
    parameter int REG_W           = pipe_pkg::REG_W,
    parameter int FUNCT_W         = pipe_pkg::FUNCT_W,
    parameter int CNT_W           = 16,
    parameter bit FLUSH_ZERO_DATA = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WB_W-1:0]    in_wb,
    input  logic [M_W-1:0]     in_m,
    input  logic [EX_W-1:0]    in_ex,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_instruction,
    input  logic [DATA_W-1:0]  in_reg1,
    input  logic [DATA_W-1:0]  in_reg2,
    input  logic [DATA_W-1:0]  in_sign_extend,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    output logic               out_valid,
    output logic [WB_W-1:0]    out_wb,
    output logic [M_W-1:0]     out_m,
    output logic [EX_W-1:0]    out_ex,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_instruction,
    output logic [DATA_W-1:0]  out_reg1,
    output logic [DATA_W-1:0]  out_reg2,
    output logic [DATA_W-1:0]  out_sign_extend,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int CTRL_W = WB_W + M_W + EX_W;

    logic stall_inc;
    logic bubble_inc;

    // Flush overrides stall, so a stall only counts when no flush is pending;
    // a bubble is either a flush or a load of an invalid instruction.
    assign stall_inc  = stall & ~flush;
    assign bubble_inc = flush | (~stall & ~in_valid);

    // Stage register: reset, then flush, then stall (hold), then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid                 <= 1'b0;
            {out_wb, out_m, out_ex}   <= '0;
            out_pc                    <= '0;
            out_instruction           <= '0;
            out_reg1                  <= '0;
            out_reg2                  <= '0;
            out_sign_extend           <= '0;
            out_funct                 <= '0;
            out_rs                    <= '0;
            out_rt                    <= '0;
            out_rd                    <= '0;
        end else if (flush) begin
            out_valid               <= 1'b0;
            {out_wb, out_m, out_ex} <= CTRL_W'(CTRL_BUBBLE);
            if (FLUSH_ZERO_DATA) begin
                out_pc          <= '0;
                out_instruction <= '0;
                out_reg1        <= '0;
                out_reg2        <= '0;
                out_sign_extend <= '0;
                out_funct       <= '0;
                out_rs          <= '0;
                out_rt          <= '0;
                out_rd          <= '0;
            end
        end else if (!stall) begin
            out_valid               <= in_valid;
            {out_wb, out_m, out_ex} <= in_valid ? {in_wb, in_m, in_ex} : CTRL_W'(CTRL_BUBBLE);
            out_pc                  <= in_pc;
            out_instruction         <= in_instruction;
            out_reg1                <= in_reg1;
            out_reg2                <= in_reg2;
            out_sign_extend         <= in_sign_extend;
            out_funct               <= in_funct;
            out_rs                  <= in_rs;
            out_rt                  <= in_rt;
            out_rd                  <= in_rd;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a reference model pushes the
// expected stage contents into a scoreboard queue each cycle; test tasks pop
// and compare after the edge. Three instances share the stimulus: default,
// FLUSH_ZERO_DATA=1, and CNT_W=2 for saturation.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] sext;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] scnt;
        logic [15:0] bcnt;
        logic        valid_b;
        logic [31:0] reg1_b;
        logic [1:0]  scnt_c;
    } exp_t;

    logic clk = 1'b0;
    logic rst, stall, flush, in_valid;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic [3:0]  in_ex;
    logic [7:0]  in_pc;
    logic [31:0] in_instruction, in_reg1, in_reg2, in_sign_extend;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs, in_rt, in_rd;

    logic        a_valid, b_valid, c_valid;
    logic [1:0]  a_wb, b_wb, c_wb;
    logic [2:0]  a_m, b_m, c_m;
    logic [3:0]  a_ex, b_ex, c_ex;
    logic [7:0]  a_pc, b_pc, c_pc;
    logic [31:0] a_instr, b_instr, c_instr, a_reg1, b_reg1, c_reg1;
    logic [31:0] a_reg2, b_reg2, c_reg2, a_sext, b_sext, c_sext;
    logic [5:0]  a_funct, b_funct, c_funct;
    logic [4:0]  a_rs, b_rs, c_rs, a_rt, b_rt, c_rt, a_rd, b_rd, c_rd;
    logic [15:0] a_scnt, a_bcnt, b_scnt, b_bcnt;
    logic [1:0]  c_scnt, c_bcnt;

    exp_t mdl;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex), .in_pc(in_pc),
        .in_instruction(in_instruction), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_sign_extend(in_sign_extend), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(a_valid), .out_wb(a_wb), .out_m(a_m), .out_ex(a_ex), .out_pc(a_pc),
        .out_instruction(a_instr), .out_reg1(a_reg1), .out_reg2(a_reg2),
        .out_sign_extend(a_sext), .out_funct(a_funct),
        .out_rs(a_rs), .out_rt(a_rt), .out_rd(a_rd),
        .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
    );

    id_ex_stage_reg #(.FLUSH_ZERO_DATA(1'b1)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex), .in_pc(in_pc),
        .in_instruction(in_instruction), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_sign_extend(in_sign_extend), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(b_valid), .out_wb(b_wb), .out_m(b_m), .out_ex(b_ex), .out_pc(b_pc),
        .out_instruction(b_instr), .out_reg1(b_reg1), .out_reg2(b_reg2),
        .out_sign_extend(b_sext), .out_funct(b_funct),
        .out_rs(b_rs), .out_rt(b_rt), .out_rd(b_rd),
        .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex), .in_pc(in_pc),
        .in_instruction(in_instruction), .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_sign_extend(in_sign_extend), .in_funct(in_funct),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(c_valid), .out_wb(c_wb), .out_m(c_m), .out_ex(c_ex), .out_pc(c_pc),
        .out_instruction(c_instr), .out_reg1(c_reg1), .out_reg2(c_reg2),
        .out_sign_extend(c_sext), .out_funct(c_funct),
        .out_rs(c_rs), .out_rt(c_rt), .out_rd(c_rd),
        .stall_cnt(c_scnt), .bubble_cnt(c_bcnt)
    );

    // Gather the observed outputs into the same shape as the model.
    function automatic exp_t sample_dut();
        exp_t s;
        s.valid = a_valid;  s.wb = a_wb;  s.m = a_m;  s.ex = a_ex;  s.pc = a_pc;
        s.instr = a_instr;  s.reg1 = a_reg1;  s.reg2 = a_reg2;  s.sext = a_sext;
        s.funct = a_funct;  s.rs = a_rs;  s.rt = a_rt;  s.rd = a_rd;
        s.scnt = a_scnt;  s.bcnt = a_bcnt;
        s.valid_b = b_valid;  s.reg1_b = b_reg1;  s.scnt_c = c_scnt;
        return s;
    endfunction

    // Reference model: compute what the stage holds after this edge, queue it, clock.
    task automatic step();
        exp_t n = mdl;
        if (rst) begin
            n = '0;
        end else if (flush) begin
            n.valid = 1'b0;  n.wb = '0;  n.m = '0;  n.ex = '0;
            n.valid_b = 1'b0;  n.reg1_b = '0;
            if (n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
        end else if (stall) begin
            if (n.scnt != 16'hFFFF) n.scnt = n.scnt + 16'd1;
            if (n.scnt_c != 2'd3) n.scnt_c = n.scnt_c + 2'd1;
        end else begin
            n.valid = in_valid;  n.valid_b = in_valid;
            n.wb = in_valid ? in_wb : 2'b00;
            n.m  = in_valid ? in_m  : 3'b000;
            n.ex = in_valid ? in_ex : 4'b0000;
            if (!in_valid && n.bcnt != 16'hFFFF) n.bcnt = n.bcnt + 16'd1;
            n.pc = in_pc;  n.instr = in_instruction;  n.reg1 = in_reg1;  n.reg2 = in_reg2;
            n.sext = in_sign_extend;  n.funct = in_funct;
            n.rs = in_rs;  n.rt = in_rt;  n.rd = in_rd;  n.reg1_b = in_reg1;
        end
        mdl = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic [3:0] ex, input logic [7:0] pc, input logic [31:0] r1,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        in_valid = v;  in_wb = wb;  in_m = m;  in_ex = ex;  in_pc = pc;  in_reg1 = r1;
        in_rs = rs;  in_rt = rt;  in_rd = rd;
        in_instruction = {pc, 24'hA5C30F};
        in_reg2 = ~r1;
        in_sign_extend = {16'hFFFF, pc, 8'h3C};
        in_funct = {1'b1, rd};
    endtask

    task automatic test_reset();
        exp_t e, a;
        drive(1'b1, 2'b11, 3'b111, 4'b1111, 8'hFF, 32'hFFFF_FFFF, 5'd31, 5'd30, 5'd29);
        rst = 1'b1;  stall = 1'b1;  flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            e = sb.pop_front();
            a = sample_dut();
            n_vec++;
            if (a !== '0) begin
                n_bad++;
                $display("[TB] FAIL reset_%0d: got %h expected %h", i, a, e);
            end
        end
        rst = 1'b0;  stall = 1'b0;
    endtask

    task automatic test_load();
        exp_t e, a;
        drive(1'b1, 2'b10, 3'b001, 4'b1100, 8'h14, 32'hDEADBEEF, 5'd3, 5'd8, 5'd9);
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if ({a.valid, a.wb, a.m, a.ex, a.pc} !== {1'b1, 2'b10, 3'b001, 4'b1100, 8'h14}) begin
            n_bad++;
            $display("[TB] FAIL load_ctrl_pc: got %h expected %h", {a.valid, a.wb, a.m, a.ex, a.pc},
                     {1'b1, 2'b10, 3'b001, 4'b1100, 8'h14});
        end
        n_vec++;
        if ({a.reg1, a.rs, a.rt, a.rd} !== {32'hDEADBEEF, 5'd3, 5'd8, 5'd9}) begin
            n_bad++;
            $display("[TB] FAIL load_data: got %h expected %h", {a.reg1, a.rs, a.rt, a.rd},
                     {32'hDEADBEEF, 5'd3, 5'd8, 5'd9});
        end
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("[TB] FAIL load_all: got %h expected %h", a, e);
        end
    endtask

    task automatic test_stall();
        exp_t e, a;
        drive(1'b1, 2'b01, 3'b010, 4'b0011, 8'h14, 32'h1111_2222, 5'd4, 5'd5, 5'd6);
        step();
        void'(sb.pop_front());
        drive(1'b1, 2'b11, 3'b100, 4'b0101, 8'h18, 32'h3333_4444, 5'd7, 5'd10, 5'd11);
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            e = sb.pop_front();
            a = sample_dut();
            n_vec++;
            if (a.pc !== 8'h14 || a.scnt !== 16'(i) || a !== e) begin
                n_bad++;
                $display("[TB] FAIL stall_hold_%0d: got pc=%h scnt=%0d all=%h expected pc=14 scnt=%0d all=%h",
                         i, a.pc, a.scnt, a, i, e);
            end
        end
        stall = 1'b0;
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if (a.pc !== 8'h18 || a.scnt !== 16'd3 || a !== e) begin
            n_bad++;
            $display("[TB] FAIL stall_release: got pc=%h scnt=%0d all=%h expected pc=18 scnt=3 all=%h",
                     a.pc, a.scnt, a, e);
        end
    endtask

    task automatic test_flush();
        exp_t e, a;
        drive(1'b1, 2'b10, 3'b001, 4'b1100, 8'h14, 32'hDEADBEEF, 5'd3, 5'd8, 5'd9);
        step();
        void'(sb.pop_front());
        flush = 1'b1;  stall = 1'b1;
        drive(1'b1, 2'b11, 3'b111, 4'b1111, 8'h20, 32'hCAFE_F00D, 5'd1, 5'd2, 5'd12);
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if ({a.valid, a.wb, a.m, a.ex} !== 10'd0) begin
            n_bad++;
            $display("[TB] FAIL flush_ctrl: got %h expected 000", {a.valid, a.wb, a.m, a.ex});
        end
        n_vec++;
        if (a.reg1 !== 32'hDEADBEEF || a.reg1_b !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL flush_data: got reg1=%h reg1_zero_variant=%h expected deadbeef/00000000",
                     a.reg1, a.reg1_b);
        end
        n_vec++;
        if (a.bcnt !== 16'd1 || a.scnt !== 16'd3) begin
            n_bad++;
            $display("[TB] FAIL flush_counters: got bubble=%0d stall=%0d expected 1/3", a.bcnt, a.scnt);
        end
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("[TB] FAIL flush_all: got %h expected %h", a, e);
        end
        flush = 1'b0;  stall = 1'b0;
    endtask

    task automatic test_invalid_load();
        exp_t e, a;
        drive(1'b0, 2'b11, 3'b101, 4'b1010, 8'h24, 32'h0BAD_0BAD, 5'd13, 5'd14, 5'd15);
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if ({a.valid, a.wb, a.m, a.ex} !== 10'd0 || a.bcnt !== 16'd2 || a.pc !== 8'h24) begin
            n_bad++;
            $display("[TB] FAIL invalid_load: got ctrl=%h bubble=%0d pc=%h expected 000/2/24",
                     {a.valid, a.wb, a.m, a.ex}, a.bcnt, a.pc);
        end
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("[TB] FAIL invalid_all: got %h expected %h", a, e);
        end
    endtask

    task automatic test_saturation();
        exp_t e, a;
        logic [1:0] want [5];
        want[0] = 2'd1;  want[1] = 2'd2;  want[2] = 2'd3;  want[3] = 2'd3;  want[4] = 2'd3;
        rst = 1'b1;
        step();
        void'(sb.pop_front());
        rst = 1'b0;  stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            e = sb.pop_front();
            a = sample_dut();
            n_vec++;
            if (a.scnt_c !== want[i] || a.scnt !== 16'(i + 1) || a !== e) begin
                n_bad++;
                $display("[TB] FAIL saturate_%0d: got narrow=%0d wide=%0d expected %0d/%0d",
                         i, a.scnt_c, a.scnt, want[i], i + 1);
            end
        end
        rst = 1'b1;
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if (a.scnt_c !== 2'd0 || a !== e) begin
            n_bad++;
            $display("[TB] FAIL saturate_reset: got narrow=%0d all=%h expected 0", a.scnt_c, a);
        end
        rst = 1'b0;  stall = 1'b0;
    endtask

    task automatic test_reset_during_stall();
        exp_t e, a;
        drive(1'b1, 2'b01, 3'b011, 4'b0110, 8'h30, 32'h5555_AAAA, 5'd16, 5'd17, 5'd18);
        step();
        void'(sb.pop_front());
        stall = 1'b1;
        step();
        void'(sb.pop_front());
        rst = 1'b1;  flush = 1'b1;
        step();
        e = sb.pop_front();
        a = sample_dut();
        n_vec++;
        if (a !== '0 || a !== e) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_stall: got %h expected all zero", a);
        end
        rst = 1'b0;  flush = 1'b0;  stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e, a;
        for (int i = 0; i < 120; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 4'($urandom),
                  8'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 40) == 0);
            step();
            e = sb.pop_front();
            a = sample_dut();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, a, e);
            end
        end
        rst = 1'b0;  stall = 1'b0;  flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 4'b0000, 8'h00, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_invalid_load();
        test_saturation();
        test_reset_during_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
